// File: rtl/heatmap_pkg.sv
// heatmap_pkg: shared definitions for the heat-map bank arbiter slice.
//   - Default geometry of the per-column M10K banks (N_COLS, COL_W, ROW_W, DATA_W).
//   - Arbiter FSM state encoding.
//   - Bit positions of the (x, y, val) fields inside a packed shared-SRAM word,
//     plus a helper that unpacks one word into a sample struct.
package heatmap_pkg;

    localparam int unsigned N_COLS = 64;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 10;
    localparam int unsigned DATA_W = 8;

    // S_IDLE  : no bank access this cycle
    // S_ACC   : a bank access is in flight
    // S_WR_GAP: wr_ack is high; a still-held wr_req is ignored here
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC    = 2'd1,
        S_WR_GAP = 2'd2
    } state_t;

    // Packed shared-SRAM sample word: X[29:20], Y[17:8], VAL[7:0]
    localparam int unsigned SRAM_X_MSB   = 29;
    localparam int unsigned SRAM_X_LSB   = 20;
    localparam int unsigned SRAM_Y_MSB   = 17;
    localparam int unsigned SRAM_Y_LSB   = 8;
    localparam int unsigned SRAM_VAL_MSB = 7;
    localparam int unsigned SRAM_VAL_LSB = 0;

    typedef struct packed {
        logic [SRAM_X_MSB-SRAM_X_LSB:0]     x;
        logic [SRAM_Y_MSB-SRAM_Y_LSB:0]     y;
        logic [SRAM_VAL_MSB-SRAM_VAL_LSB:0] val;
    } hm_sample_t;

    function automatic hm_sample_t unpack_sample(input logic [31:0] word);
        hm_sample_t s;
        s.x   = word[SRAM_X_MSB:SRAM_X_LSB];
        s.y   = word[SRAM_Y_MSB:SRAM_Y_LSB];
        s.val = word[SRAM_VAL_MSB:SRAM_VAL_LSB];
        return s;
    endfunction

endpackage

// File: rtl/heatmap_rd_pipe.sv
// heatmap_rd_pipe: read-return path of the heat-map bank arbiter.
// Delays the accepted read column and its in-range flag by RD_LAT cycles so
// they line up with the bank output, then registers the selected column slice.
// Ports:
//   clock, reset     - system clock, synchronous active-high reset
//   i_push           - a read was granted this cycle
//   i_col            - column of the granted read
//   i_bank_rdata     - flattened bank outputs, column c at [c*DATA_W +: DATA_W]
//   o_rd_valid       - read data valid (RD_LAT+1 cycles after i_push)
//   o_rd_data        - read data; zero for out-of-range columns
module heatmap_rd_pipe
    import heatmap_pkg::*;
#(
    parameter int unsigned N_COLS = heatmap_pkg::N_COLS,
    parameter int unsigned COL_W  = heatmap_pkg::COL_W,
    parameter int unsigned DATA_W = heatmap_pkg::DATA_W,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [COL_W-1:0]         i_col,
    input  logic [N_COLS*DATA_W-1:0] i_bank_rdata,
    output logic                     o_rd_valid,
    output logic [DATA_W-1:0]        o_rd_data
);

    // One extra bit so N_COLS == 2**COL_W is representable.
    localparam logic [COL_W:0] NCOLS_W = (COL_W + 1)'(N_COLS);

    logic [COL_W-1:0]  r_col [RD_LAT];
    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_inr;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_in_range;
    logic [DATA_W-1:0] w_slice;

    assign w_in_range = ({1'b0, i_col} < NCOLS_W);

    // Column mux driven by the tail of the delay chain; an unmatched index reads zero.
    always_comb begin
        w_slice = '0;
        for (int c = 0; c < int'(N_COLS); c++) begin
            if (r_col[RD_LAT-1] == COL_W'(c)) begin
                w_slice = i_bank_rdata[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_col[i] <= '0;
            end
            r_vld      <= '0;
            r_inr      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_col[0] <= i_col;
            r_vld[0] <= i_push;
            r_inr[0] <= i_push && w_in_range;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_col[i] <= r_col[i-1];
                r_vld[i] <= r_vld[i-1];
                r_inr[i] <= r_inr[i-1];
            end
            r_rd_valid <= r_vld[RD_LAT-1];
            r_rd_data  <= r_inr[RD_LAT-1] ? w_slice : '0;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/heatmap_bank_arbiter.sv
// heatmap_bank_arbiter: owns the port of the per-column heat-map M10K banks and
// shares it between the HPS update path (writes) and VGA scan-out (reads).
// Reads win every cycle, except that a write denied MAX_WAIT consecutive cycles
// is forced through, dropping that cycle's read.
// Ports:
//   clock, reset                 - system clock, synchronous active-high reset
//   i_wr_req/col/row/data        - write request, held stable until o_wr_ack
//   o_wr_ack                     - one-cycle pulse, coincident with o_bank_we
//   i_rd_req/col/row             - single-cycle read request
//   o_rd_gnt                     - combinational: read accepted this cycle
//   o_rd_valid, o_rd_data        - read return, RD_LAT+1 cycles after the grant
//   o_bank_sel/row/we/wdata      - registered bank port (one-hot column select)
//   i_bank_rdata                 - flattened bank outputs
//   o_forced_cnt                 - saturating count of forced writes
module heatmap_bank_arbiter
    import heatmap_pkg::*;
#(
    parameter int unsigned N_COLS   = heatmap_pkg::N_COLS,
    parameter int unsigned COL_W    = heatmap_pkg::COL_W,
    parameter int unsigned ROW_W    = heatmap_pkg::ROW_W,
    parameter int unsigned DATA_W   = heatmap_pkg::DATA_W,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_wr_req,
    input  logic [COL_W-1:0]         i_wr_col,
    input  logic [ROW_W-1:0]         i_wr_row,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_wr_ack,
    input  logic                     i_rd_req,
    input  logic [COL_W-1:0]         i_rd_col,
    input  logic [ROW_W-1:0]         i_rd_row,
    output logic                     o_rd_gnt,
    output logic                     o_rd_valid,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [N_COLS-1:0]        o_bank_sel,
    output logic [ROW_W-1:0]         o_bank_row,
    output logic                     o_bank_we,
    output logic [DATA_W-1:0]        o_bank_wdata,
    input  logic [N_COLS*DATA_W-1:0] i_bank_rdata,
    output logic [15:0]              o_forced_cnt
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [15:0]        r_forced_cnt;
    logic               r_wr_ack;
    logic [N_COLS-1:0]  r_bank_sel;
    logic [ROW_W-1:0]   r_bank_row;
    logic               r_bank_we;
    logic [DATA_W-1:0]  r_bank_wdata;

    logic               w_wr_elig;
    logic               w_force;
    logic               w_rd_grant;
    logic               w_wr_grant;
    logic [COL_W-1:0]   w_col;
    logic [ROW_W-1:0]   w_row;
    logic [N_COLS-1:0]  w_onehot;

    // A write is only eligible outside the ack cycle, so a held request cannot
    // be committed twice.
    assign w_wr_elig  = i_wr_req && (r_state != S_WR_GAP);
    assign w_force    = w_wr_elig && (r_wait_cnt == WAIT_MAX);
    assign w_rd_grant = i_rd_req && !w_force;
    assign w_wr_grant = w_force || (w_wr_elig && !i_rd_req);

    assign w_col = w_wr_grant ? i_wr_col : i_rd_col;
    assign w_row = w_wr_grant ? i_wr_row : i_rd_row;

    // Columns at or beyond N_COLS match no bit and leave every bank disabled.
    always_comb begin
        w_onehot = '0;
        for (int c = 0; c < int'(N_COLS); c++) begin
            if (w_col == COL_W'(c)) begin
                w_onehot[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_forced_cnt <= '0;
            r_wr_ack     <= 1'b0;
            r_bank_sel   <= '0;
            r_bank_row   <= '0;
            r_bank_we    <= 1'b0;
            r_bank_wdata <= '0;
        end else begin
            if (w_wr_grant) begin
                r_state <= S_WR_GAP;
            end else if (w_rd_grant) begin
                r_state <= S_ACC;
            end else begin
                r_state <= S_IDLE;
            end

            r_wr_ack  <= w_wr_grant;
            r_bank_we <= w_wr_grant;

            // Row and write data hold across idle cycles; only the select drops.
            if (w_wr_grant || w_rd_grant) begin
                r_bank_sel   <= w_onehot;
                r_bank_row   <= w_row;
                r_bank_wdata <= i_wr_data;
            end else begin
                r_bank_sel <= '0;
            end

            if (!i_wr_req || w_wr_grant) begin
                r_wait_cnt <= '0;
            end else if (w_wr_elig && (r_wait_cnt != WAIT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end

            if (w_force && (r_forced_cnt != 16'hFFFF)) begin
                r_forced_cnt <= r_forced_cnt + 16'd1;
            end
        end
    end

    heatmap_rd_pipe #(
        .N_COLS (N_COLS),
        .COL_W  (COL_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clock        (clock),
        .reset        (reset),
        .i_push       (w_rd_grant),
        .i_col        (i_rd_col),
        .i_bank_rdata (i_bank_rdata),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data)
    );

    assign o_rd_gnt     = w_rd_grant;
    assign o_wr_ack     = r_wr_ack;
    assign o_bank_sel   = r_bank_sel;
    assign o_bank_row   = r_bank_row;
    assign o_bank_we    = r_bank_we;
    assign o_bank_wdata = r_bank_wdata;
    assign o_forced_cnt = r_forced_cnt;

endmodule

// File: tb/tb_heatmap_bank_arbiter.sv
// Bench for heatmap_bank_arbiter with 48 column banks (columns 48..63 out of range).
module tb_heatmap_bank_arbiter;

    localparam int N        = 48;
    localparam int CW       = 6;
    localparam int RW       = 10;
    localparam int DW       = 8;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_req;
    logic [CW-1:0]     wr_col;
    logic [RW-1:0]     wr_row;
    logic [DW-1:0]     wr_data;
    logic              o_wr_ack;
    logic              rd_req;
    logic [CW-1:0]     rd_col;
    logic [RW-1:0]     rd_row;
    logic              o_rd_gnt;
    logic              o_rd_valid;
    logic [DW-1:0]     o_rd_data;
    logic [N-1:0]      o_bank_sel;
    logic [RW-1:0]     o_bank_row;
    logic              o_bank_we;
    logic [DW-1:0]     o_bank_wdata;
    logic [N*DW-1:0]   bank_rdata;
    logic [15:0]       o_forced_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    heatmap_bank_arbiter #(
        .N_COLS   (N),
        .COL_W    (CW),
        .ROW_W    (RW),
        .DATA_W   (DW),
        .RD_LAT   (RD_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_wr_req     (wr_req),
        .i_wr_col     (wr_col),
        .i_wr_row     (wr_row),
        .i_wr_data    (wr_data),
        .o_wr_ack     (o_wr_ack),
        .i_rd_req     (rd_req),
        .i_rd_col     (rd_col),
        .i_rd_row     (rd_row),
        .o_rd_gnt     (o_rd_gnt),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .o_bank_sel   (o_bank_sel),
        .o_bank_row   (o_bank_row),
        .o_bank_we    (o_bank_we),
        .o_bank_wdata (o_bank_wdata),
        .i_bank_rdata (bank_rdata),
        .o_forced_cnt (o_forced_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bank environment: M10K columns with one output register stage, which together
    // with the arbiter's registered address gives RD_LAT = 2.
    logic [DW-1:0] bmem [N][1024] = '{default: '{default: 8'h00}};
    logic [DW-1:0] brd  [N]       = '{default: 8'h00};

    always @(posedge clock) begin
        for (int c = 0; c < N; c++) begin
            if (o_bank_sel[c]) begin
                if (o_bank_we) bmem[c][o_bank_row] <= o_bank_wdata;
                else           brd[c] <= bmem[c][o_bank_row];
            end
        end
    end

    always_comb begin
        bank_rdata = '0;
        for (int c = 0; c < N; c++) bank_rdata[c*DW +: DW] = brd[c];
    end

    // Reference model: cycle-level arbitration rules, a flat memory image and a
    // queue of expected read returns keyed by due cycle.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rexp_t;

    logic [DW-1:0] rmem [N][1024] = '{default: '{default: 8'h00}};
    rexp_t         rq[$];
    rexp_t         m_ent;
    bit            m_on = 1'b0;
    int            cyc = 0;
    int            m_wait = 0;
    int            m_forced = 0;
    bit            m_gap = 1'b0;
    bit            m_elig, m_frc, m_rg, m_wg, m_rdv;
    int            m_c;
    bit            e_ack = 1'b0;
    logic [N-1:0]  e_sel = '0;
    logic [RW-1:0] e_row = '0;
    logic [DW-1:0] e_wdata = '0;

    always @(negedge clock) begin
        if (m_on) begin
            check_val("wr_ack", o_wr_ack, e_ack);
            check_val("bank_we", o_bank_we, e_ack);
            check_val("bank_sel", o_bank_sel, e_sel);
            check_val("bank_row", o_bank_row, e_row);
            check_val("bank_wdata", o_bank_wdata, e_wdata);
            check_val("forced_cnt", o_forced_cnt, m_forced);
            m_rdv = (rq.size() > 0) && (rq[0].due == cyc);
            check_val("rd_valid", o_rd_valid, m_rdv);
            if (m_rdv) begin
                m_ent = rq.pop_front();
                check_val("rd_data", o_rd_data, m_ent.d);
            end
            if (reset) begin
                e_ack = 0; e_sel = '0; e_row = '0; e_wdata = '0;
                m_forced = 0; m_wait = 0; m_gap = 0;
                rq.delete();
            end else begin
                m_elig = wr_req && !m_gap;
                m_frc  = m_elig && (m_wait == MAX_WAIT);
                m_rg   = rd_req && !m_frc;
                m_wg   = m_frc || (m_elig && !rd_req);
                check_val("rd_gnt", o_rd_gnt, m_rg);
                m_c = m_wg ? int'(wr_col) : int'(rd_col);
                if (m_rg || m_wg) begin
                    e_sel   = (m_c < N) ? (N'(1) << m_c) : '0;
                    e_row   = m_wg ? wr_row : rd_row;
                    e_wdata = wr_data;
                end else begin
                    e_sel = '0;
                end
                e_ack = m_wg;
                if (m_rg) begin
                    m_ent.due = cyc + RD_LAT + 1;
                    m_ent.d   = (int'(rd_col) < N) ? rmem[rd_col][rd_row] : '0;
                    rq.push_back(m_ent);
                end
                if (m_wg && int'(wr_col) < N) rmem[wr_col][wr_row] = wr_data;
                if (!wr_req || m_wg) m_wait = 0;
                else if (m_elig && m_wait < MAX_WAIT) m_wait++;
                if (m_frc && m_forced < 65535) m_forced++;
                m_gap = m_wg;
            end
        end
        cyc++;
    end

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit wr, input int wc, input int wrw, input int wd,
                         input bit rd, input int rc, input int rr);
        wr_req  = wr;
        wr_col  = CW'(wc);
        wr_row  = RW'(wrw);
        wr_data = DW'(wd);
        rd_req  = rd;
        rd_col  = CW'(rc);
        rd_row  = RW'(rr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            next_cyc();
        end
    endtask

    int  cnt, first, last, mode;
    bit  ack;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        m_on = 1'b1;
        next_cyc();
        reset = 1'b0;
        idle(2);

        // Single write, request held through the ack cycle.
        drive(1, 5, 100, 'hF3, 0, 0, 0);
        next_cyc();
        @(negedge clock);
        check_val("wr1_sel", o_bank_sel, 64'h20);
        check_val("wr1_row", o_bank_row, 100);
        check_val("wr1_we", o_bank_we, 1);
        check_val("wr1_wdata", o_bank_wdata, 'hF3);
        check_val("wr1_ack", o_wr_ack, 1);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check_val("wr1_no_double_we", o_bank_we, 0);
        check_val("wr1_no_double_ack", o_wr_ack, 0);
        next_cyc();
        idle(2);

        // Read latency: preload 0x42 at (47,7) through the arbiter, then read it.
        drive(1, 47, 7, 'h42, 0, 0, 0);
        next_cyc();
        idle(3);
        drive(0, 0, 0, 0, 1, 47, 7);
        @(negedge clock);
        check_val("rd_lat_gnt", o_rd_gnt, 1);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            if (i < 3) begin
                check_val("rd_lat_early", o_rd_valid, 0);
            end else begin
                check_val("rd_lat_valid", o_rd_valid, 1);
                check_val("rd_lat_data", o_rd_data, 'h42);
            end
            next_cyc();
        end
        idle(2);

        // Four back-to-back reads give four consecutive valid cycles.
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) drive(0, 0, 0, 0, 1, 10 * i + 7, 7);
            else       drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clock);
            if (o_rd_valid) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            next_cyc();
        end
        check_val("b2b_count", cnt, 4);
        check_val("b2b_first", first, 3);
        check_val("b2b_span", last - first + 1, 4);

        // Contention without force: read wins, write follows when rd_req drops.
        drive(1, 4, 4, 'h11, 1, 6, 6);
        @(negedge clock);
        check_val("cont_rd_gnt", o_rd_gnt, 1);
        next_cyc();
        drive(1, 4, 4, 'h11, 0, 0, 0);
        @(negedge clock);
        check_val("cont_no_ack_yet", o_wr_ack, 0);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check_val("cont_wr_ack", o_wr_ack, 1);
        check_val("cont_wr_sel", o_bank_sel, 64'h10);
        next_cyc();
        idle(2);

        // Out-of-range column: write acked with no bank enabled, read returns zero.
        drive(1, 50, 2, 'h77, 0, 0, 0);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check_val("oor_wr_ack", o_wr_ack, 1);
        check_val("oor_wr_sel", o_bank_sel, 0);
        next_cyc();
        idle(2);
        drive(0, 0, 0, 0, 1, 50, 2);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cyc();
        next_cyc();
        @(negedge clock);
        check_val("oor_rd_valid", o_rd_valid, 1);
        check_val("oor_rd_data", o_rd_data, 0);
        next_cyc();
        idle(3);

        // Starvation: continuous reads, write forced at cycle 15.
        for (int i = 0; i <= 16; i++) begin
            drive(1, 3, 9, 'h5A, 1, 12, 3);
            @(negedge clock);
            if (i < 15) check_val("starve_rd_gnt", o_rd_gnt, 1);
            if (i == 15) check_val("starve_force_gnt", o_rd_gnt, 0);
            if (i < 16) check_val("starve_no_ack", o_wr_ack, 0);
            if (i == 16) begin
                check_val("starve_ack", o_wr_ack, 1);
                check_val("starve_rd_resume", o_rd_gnt, 1);
                check_val("starve_forced_cnt", o_forced_cnt, 1);
            end
            next_cyc();
        end
        idle(5);

        // Reset in the cycle after a read grant.
        drive(0, 0, 0, 0, 1, 5, 100);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_sel", o_bank_sel, 0);
        check_val("rst_row", o_bank_row, 0);
        check_val("rst_we", o_bank_we, 0);
        check_val("rst_wdata", o_bank_wdata, 0);
        check_val("rst_ack", o_wr_ack, 0);
        check_val("rst_forced", o_forced_cnt, 0);
        next_cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_val("rst_no_rd_valid", o_rd_valid, 0);
            next_cyc();
        end
        drive(1, 2, 3, 'h3C, 0, 0, 0);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check_val("rst_next_wr_ack", o_wr_ack, 1);
        check_val("rst_next_wr_sel", o_bank_sel, 64'h4);
        next_cyc();
        idle(2);

        // Randomized traffic with read-pressure modes, including saturation.
        mode = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 100 == 0) mode = $urandom_range(0, 2);
            @(negedge clock);
            ack = o_wr_ack;
            @(posedge clock);
            #1;
            if (wr_req && ack) begin
                if ($urandom_range(0, 1) == 1) begin
                    wr_col  = CW'($urandom_range(0, 63));
                    wr_row  = RW'($urandom_range(0, 15));
                    wr_data = DW'($urandom);
                end else begin
                    wr_req = 1'b0;
                end
            end else if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req  = 1'b1;
                wr_col  = CW'($urandom_range(0, 63));
                wr_row  = RW'($urandom_range(0, 15));
                wr_data = DW'($urandom);
            end
            case (mode)
                0:       rd_req = ($urandom_range(0, 9) < 2);
                1:       rd_req = ($urandom_range(0, 9) < 6);
                default: rd_req = 1'b1;
            endcase
            rd_col = CW'($urandom_range(0, 63));
            rd_row = RW'($urandom_range(0, 15));
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/heatmap_bank_arbiter.md
Name: heatmap_bank_arbiter

Overview:
- Arbitrates the per-column M10K heat-map banks between two requesters:
  - the HPS update path, which writes (x, y, val) samples unpacked from shared SRAM;
  - the VGA scan-out path, which reads pixel values.
- Owns the bank port: one-hot column select, row address, write strobe, write data.
- Reads have priority. Writes are guaranteed service by a starvation bound.

Parameters:
- N_COLS, 64, number of column banks; width of the one-hot select.
- COL_W, 6, column index width; 2^COL_W must be >= N_COLS.
- ROW_W, 10, row address width.
- DATA_W, 8, heat value width (signed, passed through untouched).
- RD_LAT, 2, bank read latency in cycles from the registered address to valid bank_rdata; minimum 1.
- MAX_WAIT, 15, consecutive cycles a pending write may be denied before it is forced.

Ports:
- clock, in, 1, system clock (CLOCK_50 domain).
- reset, in, 1, synchronous active-high reset.
- wr_req, in, 1, write request; held with fields stable until wr_ack.
- wr_col, in, COL_W, write column.
- wr_row, in, ROW_W, write row.
- wr_data, in, DATA_W, write value.
- wr_ack, out, 1, one-cycle pulse: write committed to the bank.
- rd_req, in, 1, read request (single-cycle, no hold).
- rd_col, in, COL_W, read column.
- rd_row, in, ROW_W, read row.
- rd_gnt, out, 1, combinational: rd_req accepted this cycle.
- rd_valid, out, 1, read data valid.
- rd_data, out, DATA_W, read data.
- bank_sel, out, N_COLS, one-hot bank enable (registered).
- bank_row, out, ROW_W, bank row address (registered).
- bank_we, out, 1, bank write strobe (registered).
- bank_wdata, out, DATA_W, bank write data (registered).
- bank_rdata, in, N_COLS*DATA_W, flattened bank outputs; column c occupies bits [c*DATA_W +: DATA_W].
- forced_cnt, out, 16, saturating count of forced writes.

Behaviour:
- Reset values:
  - bank_sel=0, bank_row=0, bank_we=0, bank_wdata=0.
  - wr_ack=0, rd_valid=0, rd_data=0, forced_cnt=0.
  - wait_cnt=0, read pipeline cleared, FSM=S_IDLE.
- FSM has 3 states:
  - S_IDLE: no bank access this cycle.
  - S_ACC: access in flight.
  - S_WR_GAP: the cycle in which wr_ack is high. wr_req is ignored here, so a held request cannot double-write.
- Grant decision (combinational, each cycle t):
  - force = wr_req && wait_cnt==MAX_WAIT && state!=S_WR_GAP.
  - If force: grant the write. rd_gnt=0, and the read is dropped; the requester sees rd_gnt low.
  - Else if rd_req: grant the read, rd_gnt=1.
  - Else if wr_req && state!=S_WR_GAP: grant the write.
  - Else: idle.
- Registered at the end of cycle t:
  - bank_sel = one-hot(col), or all-zero if col >= N_COLS.
  - bank_row = row.
  - bank_we = 1 for a write grant.
  - bank_wdata = wr_data.
  - Idle cycle: bank_sel=0, bank_we=0; bank_row and bank_wdata hold their values.
- Write completion:
  - wr_ack=1 in cycle t+1, coincident with bank_we. FSM enters S_WR_GAP for that cycle.
  - The requester must drop wr_req or present the next sample by t+2.
- wait_cnt:
  - Increments each cycle that wr_req is high, state!=S_WR_GAP, and the write is not granted.
  - Clears on write grant or when wr_req is low.
  - Saturates at MAX_WAIT.
- forced_cnt: increments on each forced grant; saturates at 16'hFFFF.
- Read pipeline:
  - The accepted column index and an in-range bit shift through an RD_LAT-deep register chain.
  - rd_valid=1 exactly RD_LAT+1 cycles after the grant cycle. rd_data is registered from the bank_rdata slice selected by the delayed column.
  - Out-of-range column: rd_valid asserts with rd_data=0.
  - Back-to-back reads are sustained at 1 per cycle.
- Out-of-range write: acked normally; no bank enabled.
- Simultaneous rd_req and wr_req: the read wins unless force.
- With MAX_WAIT=0, every pending write is forced immediately.
- Reset mid-operation:
  - Pipeline flushed; rd_valid is low from the cycle after reset.
  - A pending write is not acked; the requester must re-issue it.

Decomposition:
- Package heatmap_pkg:
  - localparams N_COLS, COL_W, ROW_W, DATA_W.
  - FSM state encodings S_IDLE, S_ACC, S_WR_GAP.
  - Packed SRAM word field positions: X[29:20], Y[17:8], VAL[7:0].
- One sub-module: heatmap_rd_pipe, the RD_LAT-deep column/valid delay chain plus the output slice mux.

Test Plan:
- Single write: wr_req col=5 row=100 data=8'hF3, rd_req low.
  - Next cycle: bank_sel=64'h20, bank_row=100, bank_we=1, bank_wdata=F3, wr_ack=1.
  - wr_req held one extra cycle: no second write.
- Read latency, RD_LAT=2: rd_req col=63 row=7 at cycle 0, bank model returns 8'h42 in column 63.
  - rd_gnt=1 at cycle 0; rd_valid=1, rd_data=42 at cycle 3.
  - 4 back-to-back reads produce 4 consecutive rd_valid cycles.
- Starvation: rd_req held high continuously, wr_req asserted at cycle 0.
  - rd_gnt low and write granted at cycle 15; wr_ack at cycle 16; forced_cnt=1; reads resume at cycle 16.
- Contention without force: rd_req and wr_req both asserted in one cycle with wait_cnt=0.
  - Read granted; write granted the first cycle rd_req is low.
- Out-of-range: N_COLS=48, write to col=50 is acked with bank_sel=0; read of col=50 gives rd_valid with rd_data=0.
- Reset at the cycle after a read grant: rd_valid never asserts; all outputs return to reset values; next write is acked normally.
